// File: rtl/cond_eval_unit.sv
// Registered Bicc/Ticc condition evaluator with banked integer condition codes,
// a held software-trap request with ack handshake, and a saturating taken-branch counter.
module cond_eval_unit #(
  parameter  int NCC   = 2,
  parameter  int TT_W  = 8,
  parameter  int CNT_W = 16,
  localparam int SELW  = (NCC > 1) ? $clog2(NCC) : 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cc_we,
  input  logic [SELW-1:0]  i_cc_wsel,
  input  logic [3:0]       i_cc_in,
  input  logic             i_ir_valid,
  input  logic [31:0]      i_ir,
  input  logic [SELW-1:0]  i_cc_rsel,
  input  logic [6:0]       i_swtn,
  input  logic             i_flush,
  input  logic             i_trap_ack,
  output logic             o_res_valid,
  output logic             o_bcond,
  output logic             o_tcond,
  output logic             o_annul,
  output logic             o_trap_req,
  output logic [TT_W-1:0]  o_trap_tt,
  output logic             o_stall,
  output logic [CNT_W-1:0] o_taken_cnt
);

  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [SELW:0] NCC_L = (SELW+1)'(NCC);

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_cc [NCC];
  logic             r_res_valid, r_bcond, r_tcond, r_annul;
  logic [TT_W-1:0]  r_trap_tt;
  logic [CNT_W-1:0] r_taken_cnt;

  logic             w_wr_ok;
  logic [SELW-1:0]  w_rsel;
  logic [3:0]       w_cc;
  logic             w_n, w_z, w_v, w_c;
  logic             w_is_bicc, w_is_ticc, w_a;
  logic [3:0]       w_cond;
  logic             w_base, w_taken;
  logic             w_stall, w_accept, w_b_taken, w_t_taken;
  logic             w_unused_ir;

  assign w_wr_ok = i_cc_we && ({1'b0, i_cc_wsel} < NCC_L);
  assign w_rsel  = ({1'b0, i_cc_rsel} < NCC_L) ? i_cc_rsel : '0;
  // A bank being written this cycle is seen by the evaluation of the same cycle.
  assign w_cc    = (w_wr_ok && (i_cc_wsel == w_rsel)) ? i_cc_in : r_cc[w_rsel];
  assign {w_n, w_z, w_v, w_c} = w_cc;

  assign w_is_bicc   = (i_ir[31:30] == 2'b00) && (i_ir[24:22] == 3'b010);
  assign w_is_ticc   = (i_ir[31:30] == 2'b10) && (i_ir[24:19] == 6'b111010);
  assign w_cond      = i_ir[28:25];
  assign w_a         = i_ir[29];
  assign w_unused_ir = ^i_ir[18:0];

  always_comb begin
    w_base = 1'b0;
    case (w_cond[2:0])
      3'b000:  w_base = 1'b0;
      3'b001:  w_base = w_z;
      3'b010:  w_base = w_z | (w_n ^ w_v);
      3'b011:  w_base = w_n ^ w_v;
      3'b100:  w_base = w_c | w_z;
      3'b101:  w_base = w_c;
      3'b110:  w_base = w_n;
      default: w_base = w_v;
    endcase
  end

  assign w_taken   = w_base ^ w_cond[3];
  assign w_stall   = (r_state == REQ);
  assign w_accept  = i_ir_valid && !w_stall && !i_flush;
  assign w_b_taken = w_accept && w_is_bicc && w_taken;
  assign w_t_taken = w_accept && w_is_ticc && w_taken;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NCC; i++) r_cc[i] <= 4'b0000;
    end else if (w_wr_ok) begin
      r_cc[i_cc_wsel] <= i_cc_in;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_t_taken)  w_next = REQ;
      REQ:     if (i_trap_ack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Result flags are single-cycle pulses; anything not accepted leaves them low.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_res_valid <= 1'b0;
      r_bcond     <= 1'b0;
      r_tcond     <= 1'b0;
      r_annul     <= 1'b0;
      r_trap_tt   <= '0;
      r_taken_cnt <= '0;
    end else begin
      r_res_valid <= w_accept && (w_is_bicc || w_is_ticc);
      r_bcond     <= w_b_taken;
      r_tcond     <= w_t_taken;
      r_annul     <= w_accept && w_is_bicc && w_a && (!w_taken || (w_cond == 4'b1000));
      if (w_t_taken)
        r_trap_tt <= TT_W'({1'b1, i_swtn});
      if (w_b_taken && (r_taken_cnt != '1))
        r_taken_cnt <= r_taken_cnt + CNT_W'(1);
    end
  end

  assign o_res_valid = r_res_valid;
  assign o_bcond     = r_bcond;
  assign o_tcond     = r_tcond;
  assign o_annul     = r_annul;
  assign o_trap_req  = w_stall;
  assign o_stall     = w_stall;
  assign o_trap_tt   = r_trap_tt;
  assign o_taken_cnt = r_taken_cnt;

endmodule

// File: tb/tb_cond_eval_unit.sv
// Directed self-checking bench for cond_eval_unit: a default instance plus a
// CNT_W=2 instance sharing the same stimulus to exercise counter saturation.
module tb_cond_eval_unit;

  logic        clk = 1'b0;
  logic        reset, ccWe, ccWsel, irValid, ccRsel, flush, trapAck;
  logic [3:0]  ccIn;
  logic [31:0] ir;
  logic [6:0]  swtn;

  logic        resValid, bcond, tcond, annul, trapReq, stall;
  logic [7:0]  trapTt;
  logic [15:0] takenCnt;

  logic        sResValid, sBcond, sTcond, sAnnul, sTrapReq, sStall;
  logic [7:0]  sTrapTt;
  logic [1:0]  sTakenCnt;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  cond_eval_unit dut (
    .i_clk(clk), .i_reset(reset), .i_cc_we(ccWe), .i_cc_wsel(ccWsel), .i_cc_in(ccIn),
    .i_ir_valid(irValid), .i_ir(ir), .i_cc_rsel(ccRsel), .i_swtn(swtn), .i_flush(flush),
    .i_trap_ack(trapAck), .o_res_valid(resValid), .o_bcond(bcond), .o_tcond(tcond),
    .o_annul(annul), .o_trap_req(trapReq), .o_trap_tt(trapTt), .o_stall(stall),
    .o_taken_cnt(takenCnt)
  );

  cond_eval_unit #(.CNT_W(2)) dutSmall (
    .i_clk(clk), .i_reset(reset), .i_cc_we(ccWe), .i_cc_wsel(ccWsel), .i_cc_in(ccIn),
    .i_ir_valid(irValid), .i_ir(ir), .i_cc_rsel(ccRsel), .i_swtn(swtn), .i_flush(flush),
    .i_trap_ack(trapAck), .o_res_valid(sResValid), .o_bcond(sBcond), .o_tcond(sTcond),
    .o_annul(sAnnul), .o_trap_req(sTrapReq), .o_trap_tt(sTrapTt), .o_stall(sStall),
    .o_taken_cnt(sTakenCnt)
  );

  function automatic logic [31:0] mkBicc(input logic a, input logic [3:0] cond);
    return {2'b00, a, cond, 3'b010, 22'd0};
  endfunction

  function automatic logic [31:0] mkTicc(input logic [3:0] cond);
    return {2'b10, 1'b0, cond, 6'b111010, 19'd0};
  endfunction

  // Inputs change 1 time unit after the rising edge, outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] instr, input logic rsel,
                               input logic we, input logic wsel, input logic [3:0] cc);
    irValid = valid;
    ir      = instr;
    ccRsel  = rsel;
    ccWe    = we;
    ccWsel  = wsel;
    ccIn    = cc;
    step();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; ccWe = 0; ccWsel = 0; ccIn = 0; irValid = 0; ir = 0;
    ccRsel = 0; swtn = 0; flush = 0; trapAck = 0;
    step(); step();
    checkOutput("rst_res_valid", resValid, 0);
    checkOutput("rst_bcond", bcond, 0);
    checkOutput("rst_trap_req", trapReq, 0);
    checkOutput("rst_trap_tt", trapTt, 0);
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_cnt", takenCnt, 0);
    reset = 1'b0;

    $display("[TB] basic Bicc evaluation");
    applyStimulus(0, 0, 0, 1, 0, 4'b0100);
    applyStimulus(1, mkBicc(0, 4'b0001), 0, 0, 0, 0);
    checkOutput("be_res_valid", resValid, 1);
    checkOutput("be_bcond", bcond, 1);
    checkOutput("be_tcond", tcond, 0);
    checkOutput("be_annul", annul, 0);
    checkOutput("be_cnt", takenCnt, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("res_valid_pulse", resValid, 0);

    applyStimulus(0, 0, 0, 1, 0, 4'b0000);
    applyStimulus(1, mkBicc(1, 4'b0001), 0, 0, 0, 0);
    checkOutput("be_a_bcond", bcond, 0);
    checkOutput("be_a_annul", annul, 1);
    checkOutput("be_a_cnt", takenCnt, 1);
    applyStimulus(1, mkBicc(1, 4'b1000), 0, 0, 0, 0);
    checkOutput("ba_a_bcond", bcond, 1);
    checkOutput("ba_a_annul", annul, 1);
    checkOutput("ba_a_cnt", takenCnt, 2);

    $display("[TB] forwarding and bank select");
    applyStimulus(1, mkBicc(0, 4'b0110), 1, 1, 1, 4'b1000);
    checkOutput("fwd_bcond", bcond, 1);
    checkOutput("fwd_annul", annul, 0);
    checkOutput("fwd_cnt", takenCnt, 3);
    applyStimulus(1, mkBicc(0, 4'b0110), 0, 1, 1, 4'b1000);
    checkOutput("bank0_bneg", bcond, 0);
    checkOutput("bank0_res_valid", resValid, 1);
    applyStimulus(1, mkBicc(0, 4'b0011), 1, 0, 0, 0);
    checkOutput("bl_bank1", bcond, 1);
    applyStimulus(1, mkBicc(0, 4'b1001), 0, 0, 0, 0);
    checkOutput("bne_bank0", bcond, 1);
    checkOutput("cnt_after_fwd", takenCnt, 5);
    applyStimulus(1, 32'h8000_0000, 0, 0, 0, 0);
    checkOutput("other_res_valid", resValid, 0);

    $display("[TB] Ticc and trap handshake");
    applyStimulus(1, mkTicc(4'b0000), 0, 0, 0, 0);
    checkOutput("tn_res_valid", resValid, 1);
    checkOutput("tn_tcond", tcond, 0);
    checkOutput("tn_trap_req", trapReq, 0);
    swtn = 7'h05;
    applyStimulus(1, mkTicc(4'b1000), 0, 0, 0, 0);
    checkOutput("ta_res_valid", resValid, 1);
    checkOutput("ta_tcond", tcond, 1);
    checkOutput("ta_bcond", bcond, 0);
    checkOutput("ta_annul", annul, 0);
    checkOutput("ta_trap_req", trapReq, 1);
    checkOutput("ta_trap_tt", trapTt, 8'h85);
    checkOutput("ta_stall", stall, 1);
    swtn = 7'h11;
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      applyStimulus(1, mkBicc(0, 4'b1000), 0, 0, 0, 0);
      checkOutput("hold_trap_req", trapReq, 1);
      checkOutput("hold_res_valid", resValid, 0);
      checkOutput("hold_trap_tt", trapTt, 8'h85);
    end
    flush = 0;
    trapAck = 1;
    step();
    trapAck = 0;
    checkOutput("ack_trap_req", trapReq, 0);
    checkOutput("ack_stall", stall, 0);
    checkOutput("ack_res_valid", resValid, 0);
    checkOutput("ack_cnt", takenCnt, 5);
    step();
    checkOutput("held_ir_bcond", bcond, 1);
    checkOutput("held_ir_cnt", takenCnt, 6);
    irValid = 0;
    trapAck = 1;
    step();
    trapAck = 0;
    checkOutput("idle_ack_ignored", trapReq, 0);

    $display("[TB] reset while trap pending");
    applyStimulus(0, 0, 0, 1, 0, 4'b0100);
    swtn = 7'h7F;
    applyStimulus(1, mkTicc(4'b1000), 0, 0, 0, 0);
    checkOutput("tt_7f", trapTt, 8'hFF);
    irValid = 0;
    reset = 1;
    step();
    reset = 0;
    checkOutput("rreq_trap_req", trapReq, 0);
    checkOutput("rreq_trap_tt", trapTt, 0);
    checkOutput("rreq_cnt", takenCnt, 0);
    applyStimulus(1, mkBicc(0, 4'b0001), 0, 0, 0, 0);
    checkOutput("rreq_bank_clear", bcond, 0);
    checkOutput("rreq_bank_valid", resValid, 1);

    $display("[TB] counter saturation and flush");
    irValid = 1;
    ir = mkBicc(0, 4'b1000);
    repeat (5) step();
    irValid = 0;
    checkOutput("cnt16_five", takenCnt, 5);
    checkOutput("cnt2_sat", sTakenCnt, 3);
    flush = 1;
    applyStimulus(1, mkBicc(0, 4'b1000), 0, 0, 0, 0);
    flush = 0;
    irValid = 0;
    checkOutput("flush_res_valid", resValid, 0);
    checkOutput("flush_bcond", bcond, 0);
    checkOutput("flush_cnt16", takenCnt, 5);
    checkOutput("flush_cnt2", sTakenCnt, 3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
